// File: rtl/seq_mcycle_gen.sv
// Machine-cycle sequencer: one-hot T-states, M-cycle index and registered #MREQ.
// Latency: start to T1 is one cycle; done pulses one cycle after the final T_N.
// Backpressure: stall holds the sequence in T_N; start is taken only in IDLE or at the final T_N.
module seq_mcycle_gen #(
    parameter int TSTATES = 4,
    parameter int MCW     = 3
) (
    input  logic               clk,
    input  logic               nres,
    input  logic               start,
    input  logic [MCW-1:0]     mlen,
    input  logic               mem_en,
    input  logic               stall,
    input  logic               abort,
    output logic [TSTATES-1:0] tstate,
    output logic [MCW-1:0]     mcycle,
    output logic               busy,
    output logic               last_m,
    output logic               done,
    output logic               nmreq
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [TSTATES-1:0] T1    = TSTATES'(1);
    localparam logic [MCW-1:0]     ONE_M = MCW'(1);

    state_t             state_q, state_d;
    logic [TSTATES-1:0] tstate_d;
    logic [MCW-1:0]     mcycle_d;
    logic [MCW-1:0]     len_q, len_d;
    logic               abort_q, abort_d;
    logic               busy_d, last_m_d, done_d, nmreq_d;

    logic               t_first, t_last;
    logic [MCW-1:0]     start_len;

    assign t_first   = tstate[0];
    assign t_last    = tstate[TSTATES-1];
    assign start_len = (mlen == '0) ? ONE_M : mlen;

    always_comb begin
        state_d  = state_q;
        tstate_d = tstate;
        mcycle_d = mcycle;
        len_d    = len_q;
        abort_d  = abort_q;
        done_d   = 1'b0;
        nmreq_d  = nmreq;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    tstate_d = T1;
                    mcycle_d = '0;
                    len_d    = start_len;
                    abort_d  = 1'b0;
                    nmreq_d  = 1'b1;
                end
            end
            RUN: begin
                if (abort) abort_d = 1'b1;
                if (!t_last) begin
                    tstate_d = {tstate[TSTATES-2:0], 1'b0};
                    // mem_en seen in T1 decides #MREQ for the rest of this M-cycle
                    if (t_first) nmreq_d = ~mem_en;
                end else if (!stall) begin
                    nmreq_d = 1'b1;
                    // abort arriving in the final T-state still ends after this M-cycle
                    if (last_m || abort) begin
                        done_d = 1'b1;
                        if (start) begin
                            tstate_d = T1;
                            mcycle_d = '0;
                            len_d    = start_len;
                            abort_d  = 1'b0;
                        end else begin
                            state_d  = IDLE;
                            tstate_d = '0;
                            mcycle_d = '0;
                            abort_d  = 1'b0;
                        end
                    end else begin
                        tstate_d = T1;
                        mcycle_d = mcycle + ONE_M;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d == RUN);
        last_m_d = busy_d && ((mcycle_d == len_d - ONE_M) || abort_d);
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= IDLE;
            tstate  <= '0;
            mcycle  <= '0;
            len_q   <= '0;
            abort_q <= 1'b0;
            busy    <= 1'b0;
            last_m  <= 1'b0;
            done    <= 1'b0;
            nmreq   <= 1'b1;
        end else begin
            state_q <= state_d;
            tstate  <= tstate_d;
            mcycle  <= mcycle_d;
            len_q   <= len_d;
            abort_q <= abort_d;
            busy    <= busy_d;
            last_m  <= last_m_d;
            done    <= done_d;
            nmreq   <= nmreq_d;
        end
    end

endmodule

// File: tb/tb_seq_mcycle_gen.sv
// Bench for seq_mcycle_gen: vector table, directed multi-cycle cases and random stimulus vs a phase/count model.
module tb_seq_mcycle_gen;
    localparam int N   = 4;
    localparam int MCW = 3;

    logic           clk = 1'b0;
    logic           nres = 1'b1;
    logic           start = 1'b0, mem_en = 1'b0, stall = 1'b0, abort = 1'b0;
    logic [MCW-1:0] mlen = '0;
    logic [N-1:0]   tstate;
    logic [MCW-1:0] mcycle;
    logic           busy, last_m, done, nmreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mcycle_gen #(.TSTATES(N), .MCW(MCW)) dut (
        .clk(clk), .nres(nres), .start(start), .mlen(mlen), .mem_en(mem_en),
        .stall(stall), .abort(abort), .tstate(tstate), .mcycle(mcycle),
        .busy(busy), .last_m(last_m), .done(done), .nmreq(nmreq)
    );

    // Reference: phase number, M-cycle number, length, abort and memory-request flags
    bit m_run, m_ab, m_req, m_done;
    int m_t, m_m, m_len;

    task automatic model_reset();
        m_run = 0; m_t = 0; m_m = 0; m_len = 0; m_ab = 0; m_req = 0; m_done = 0;
    endtask

    task automatic model_begin(input int ml);
        m_run = 1; m_t = 0; m_m = 0; m_len = (ml == 0) ? 1 : ml; m_ab = 0; m_req = 0;
    endtask

    task automatic model_step();
        bit nd;
        nd = 0;
        if (!nres) begin
            model_reset();
        end else begin
            if (!m_run) begin
                if (start) model_begin(int'(mlen));
            end else if (m_t < N - 1) begin
                if (m_t == 0) m_req = mem_en;
                m_t++;
                if (abort) m_ab = 1;
            end else if (stall) begin
                if (abort) m_ab = 1;
            end else if (m_m == m_len - 1 || m_ab || abort) begin
                nd = 1;
                if (start) model_begin(int'(mlen));
                else begin
                    m_run = 0; m_t = 0; m_m = 0; m_ab = 0;
                end
            end else begin
                m_t = 0;
                m_m++;
            end
            m_done = nd;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        int ets;
        ets = m_run ? (1 << m_t) : 0;
        check("tstate", int'(tstate), ets);
        check("mcycle", int'(mcycle), m_run ? m_m : 0);
        check("busy", int'(busy), int'(m_run));
        check("last_m", int'(last_m), int'(m_run && (m_m == m_len - 1 || m_ab)));
        check("done", int'(done), int'(m_done));
        check("nmreq", int'(nmreq), int'(!(m_run && m_t >= 1 && m_req)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic           start;
        logic [MCW-1:0] mlen;
        logic           mem_en, stall, abort;
        logic [N-1:0]   ts;
        logic [MCW-1:0] mc;
        logic           busy, last_m, done, nmreq;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_cnt, done_cnt, done_at, low_cnt, m1_low, hold, hold_low, sc, k;
        int first_done, last_done, coincide, idle_cnt;
        bit sent, prev_abort;

        // async reset before any clock edge
        model_reset();
        #1 nres = 1'b0;
        #1;
        check("rst_tstate", int'(tstate), 0);
        check("rst_mcycle", int'(mcycle), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_nmreq", int'(nmreq), 1);
        check("rst_last_m", int'(last_m), 0);
        @(negedge clk);
        nres = 1'b1;

        //          start mlen mem stall abrt  ts       mc busy last done nmreq
        tbl[0]  = '{1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 4'b0010, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0100, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'b0010, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 4'b0100, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 4'b1000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; mlen = tbl[i].mlen; mem_en = tbl[i].mem_en;
            stall = tbl[i].stall; abort = tbl[i].abort;
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("vec%0d_tstate", i), int'(tstate), int'(tbl[i].ts));
            check($sformatf("vec%0d_mcycle", i), int'(mcycle), int'(tbl[i].mc));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("vec%0d_last_m", i), int'(last_m), int'(tbl[i].last_m));
            check($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].done));
            check($sformatf("vec%0d_nmreq", i), int'(nmreq), int'(tbl[i].nmreq));
        end
        start = 0; stall = 0; abort = 0; mem_en = 0;
        cycle();

        // mlen=3, memory access in M0 and M2 only
        start = 1; mlen = 3'd3; mem_en = 1;
        cycle();
        start = 0;
        n = 1; busy_cnt = 0; done_cnt = 0; done_at = 0; low_cnt = 0; m1_low = 0;
        for (k = 0; k < 40 && done_cnt == 0; k++) begin
            if (busy) busy_cnt++;
            if (!nmreq) low_cnt++;
            if (!nmreq && mcycle == 3'd1) m1_low++;
            mem_en = (m_m != 1);
            cycle();
            n++;
            if (done) begin done_cnt++; done_at = n; end
        end
        check("t2_busy_cycles", busy_cnt, 12);
        check("t2_done_cycle", done_at, 13);
        check("t2_nmreq_low_cycles", low_cnt, 6);
        check("t2_nmreq_low_in_m1", m1_low, 0);
        check("t2_busy_at_done", int'(busy), 0);
        cycle();
        check("t2_done_single", int'(done), 0);

        // mlen=2 with a 3-cycle stall at T4 of M0
        start = 1; mlen = 3'd2; mem_en = 1;
        cycle();
        start = 0;
        busy_cnt = 0; hold = 0; hold_low = 0; sc = 0;
        for (k = 0; k < 40 && !done; k++) begin
            if (busy) busy_cnt++;
            if (tstate == 4'b1000 && mcycle == 3'd0) begin
                hold++;
                if (!nmreq) hold_low++;
            end
            stall = (m_t == N - 1 && m_m == 0 && sc < 3);
            if (stall) sc++;
            cycle();
        end
        stall = 0;
        check("t3_t4_hold_cycles", hold, 4);
        check("t3_nmreq_low_in_hold", hold_low, 4);
        check("t3_busy_cycles", busy_cnt, 11);
        cycle();

        // mlen=5, abort at T2 of M0
        start = 1; mlen = 3'd5; mem_en = 0;
        cycle();
        start = 0;
        busy_cnt = 0; sent = 0; prev_abort = 0;
        for (k = 0; k < 40 && !done; k++) begin
            if (prev_abort) check("t4_last_m_after_abort", int'(last_m), 1);
            if (busy) busy_cnt++;
            abort = (m_t == 1 && m_m == 0 && !sent);
            prev_abort = abort;
            if (abort) sent = 1;
            cycle();
            abort = 0;
        end
        check("t4_busy_cycles", busy_cnt, 4);
        check("t4_done", int'(done), 1);
        check("t4_mcycle_end", int'(mcycle), 0);
        check("t4_busy_end", int'(busy), 0);
        cycle();

        // start held high, mlen=2: back-to-back 8-cycle sequences
        start = 1; mlen = 3'd2;
        cycle();
        first_done = 0; last_done = 0; done_cnt = 0; coincide = 0; idle_cnt = 0;
        for (n = 1; n <= 30; n++) begin
            if (!busy) idle_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
                last_done = n;
                if (tstate == 4'b0001 && mcycle == 3'd0) coincide++;
            end
            cycle();
        end
        check("t5_done_count", done_cnt, 3);
        check("t5_first_done", first_done, 9);
        check("t5_last_done", last_done, 25);
        check("t5_done_at_t1", coincide, 3);
        check("t5_idle_gap", idle_cnt, 0);
        start = 0;
        for (k = 0; k < 20 && busy; k++) cycle();
        check("t5_drained", int'(busy), 0);
        cycle();

        // reset at T3 of M1 of an mlen=3 run
        start = 1; mlen = 3'd3; mem_en = 1;
        cycle();
        start = 0;
        for (k = 0; k < 40 && !(m_t == 2 && m_m == 1); k++) cycle();
        check("t6_reached_m1_t3", int'(tstate), 4);
        #2 nres = 1'b0;
        #1;
        model_reset();
        check("t6_rst_tstate", int'(tstate), 0);
        check("t6_rst_mcycle", int'(mcycle), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_nmreq", int'(nmreq), 1);
        check("t6_rst_last_m", int'(last_m), 0);
        cycle();
        @(negedge clk);
        nres = 1'b1;
        done_cnt = 0;
        for (k = 0; k < 10; k++) begin
            cycle();
            if (done) done_cnt++;
        end
        check("t6_no_done_after_reset", done_cnt, 0);
        start = 1; mlen = 3'd1;
        cycle();
        start = 0;
        for (k = 0; k < 20 && !done; k++) cycle();
        check("t6_clean_restart_done", int'(done), 1);
        cycle();

        // randomized stimulus against the model
        for (int r = 0; r < 3000; r++) begin
            start  = ($urandom_range(0, 3) == 0);
            mlen   = MCW'($urandom);
            mem_en = 1'($urandom);
            stall  = ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 19) == 0);
            cycle();
            if ($urandom_range(0, 499) == 0) begin
                #2 nres = 1'b0;
                #1;
                model_reset();
                cmp_model();
                @(negedge clk);
                nres = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
